// File: rtl/lif_pkg.sv
// Shared types, register map offsets and arithmetic helpers for the
// leaky integrate-and-fire neuron array.
package lif_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2,
    ST_LEAK  = 2'd3
  } state_e;

  // Register-space offsets are relative to NUM_NEURONS (potentials come first).
  localparam int REG_THRESH_OFS = 0;
  localparam int REG_STATUS_OFS = 1;

  localparam int STATUS_BUSY    = 0;
  localparam int STATUS_OVERRUN = 1;

  // Signed add clamped to the range of a width-bit two's complement value.
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int width);
    logic signed [32:0] sum;
    logic signed [32:0] hi;
    logic signed [32:0] lo;
    sum = {a[31], a} + {b[31], b};
    hi  = (33'sd1 <<< (width - 1)) - 33'sd1;
    lo  = -hi - 33'sd1;
    if (sum > hi) return 32'(hi);
    if (sum < lo) return 32'(lo);
    return 32'(sum);
  endfunction

endpackage

// File: rtl/lif_neuron_datapath.sv
// Combinational update of one neuron: integrate-and-fire in accumulate mode,
// exponential leak plus refractory countdown in leak mode.
module lif_neuron_datapath
  import lif_pkg::*;
#(
  parameter int DW            = 16,
  parameter int LEAK_SHIFT    = 4,
  parameter int REFRACT_TICKS = 2,
  parameter int RW            = 2
) (
  input  logic signed [DW-1:0] v,
  input  logic signed [DW-1:0] w,
  input  logic signed [DW-1:0] threshold,
  input  logic                 leak_mode,
  input  logic [RW-1:0]        refract,
  output logic signed [DW-1:0] v_next,
  output logic                 fire,
  output logic [RW-1:0]        refract_next
);

  logic signed [DW-1:0] sum;

  always_comb begin
    sum          = DW'(sat_add(32'(v), 32'(w), DW));
    v_next       = v;
    fire         = 1'b0;
    refract_next = refract;
    if (leak_mode) begin
      // Arithmetic shift rounds toward -inf, so the step never crosses zero.
      v_next = v - (v >>> LEAK_SHIFT);
      if (refract != '0) refract_next = refract - RW'(1);
    end else if (refract == '0) begin
      if (sum >= threshold) begin
        v_next       = '0;
        fire         = 1'b1;
        refract_next = RW'(REFRACT_TICKS);
      end else begin
        v_next = sum;
      end
    end
  end

endmodule

// File: rtl/lif_neuron_array.sv
// Array of LIF neurons sharing one datapath; events and leak ticks are applied
// to the neurons one per cycle, configuration and readback via a simple bus.
module lif_neuron_array
  import lif_pkg::*;
#(
  parameter int NUM_NEURONS   = 4,
  parameter int NUM_SYNAPSES  = 8,
  parameter int DATA_WIDTH    = 16,
  parameter int LEAK_SHIFT    = 4,
  parameter int REFRACT_TICKS = 2,
  parameter int THRESH_RESET  = 1000,
  parameter int ADDR_WIDTH    = $clog2(NUM_NEURONS * NUM_SYNAPSES) + 1
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            bus_read,
  input  logic                            bus_write,
  input  logic [ADDR_WIDTH-1:0]           bus_addr,
  input  logic [DATA_WIDTH-1:0]           bus_wdata,
  output logic [DATA_WIDTH-1:0]           bus_rdata,
  input  logic                            evt_valid,
  output logic                            evt_ready,
  input  logic [$clog2(NUM_SYNAPSES)-1:0] evt_synapse,
  input  logic                            leak_tick,
  output logic                            spike_valid,
  output logic [NUM_NEURONS-1:0]          spike_mask,
  output logic [1:0]                      dbg_state
);

  localparam int DW = DATA_WIDTH;
  localparam int NW = $clog2(NUM_NEURONS);
  localparam int SW = $clog2(NUM_SYNAPSES);
  localparam int OW = ADDR_WIDTH - 1;
  localparam int RW = (REFRACT_TICKS > 0) ? $clog2(REFRACT_TICKS + 1) : 1;

  state_e                state;
  logic [NW-1:0]         idx;
  logic [SW-1:0]         syn_q;
  logic [NUM_NEURONS-1:0] mask_acc;
  logic signed [DW-1:0]  thresh;
  logic                  leak_pending;
  logic                  leak_overrun;
  logic signed [DW-1:0]  pot  [NUM_NEURONS];
  logic [RW-1:0]         refr [NUM_NEURONS];
  logic signed [DW-1:0]  wmem [NUM_NEURONS*NUM_SYNAPSES];

  logic                  is_reg, pot_hit, thr_hit, stat_hit;
  logic [OW-1:0]         ofs;
  logic [DW-1:0]         status_word, rd_mux;
  logic                  accept, leak_start;
  logic signed [DW-1:0]  dp_v;
  logic                  dp_fire;
  logic [RW-1:0]         dp_r;

  assign is_reg   = bus_addr[ADDR_WIDTH-1];
  assign ofs      = bus_addr[OW-1:0];
  assign pot_hit  = is_reg && (ofs < OW'(NUM_NEURONS));
  assign thr_hit  = is_reg && (ofs == OW'(NUM_NEURONS + REG_THRESH_OFS));
  assign stat_hit = is_reg && (ofs == OW'(NUM_NEURONS + REG_STATUS_OFS));

  // evt_valid/evt_ready: an event transfers on a rising clk edge where both are
  // high; evt_synapse must be stable while evt_valid is high, and evt_ready never
  // depends on evt_valid. A leak tick in the same cycle wins over the event.
  assign evt_ready  = (state == ST_IDLE) && !leak_pending && !leak_tick;
  assign accept     = evt_valid && evt_ready;
  assign leak_start = leak_pending && ((state == ST_IDLE) || (state == ST_DONE));
  assign dbg_state  = state;

  always_comb begin
    status_word                 = '0;
    status_word[STATUS_BUSY]    = (state != ST_IDLE);
    status_word[STATUS_OVERRUN] = leak_overrun;
    rd_mux = '0;
    if (!is_reg)       rd_mux = wmem[ofs];
    else if (pot_hit)  rd_mux = pot[ofs[NW-1:0]];
    else if (thr_hit)  rd_mux = thresh;
    else if (stat_hit) rd_mux = status_word;
  end

  lif_neuron_datapath #(
    .DW(DW), .LEAK_SHIFT(LEAK_SHIFT), .REFRACT_TICKS(REFRACT_TICKS), .RW(RW)
  ) u_dp (
    .v(pot[idx]),
    .w(wmem[{idx, syn_q}]),
    .threshold(thresh),
    .leak_mode(state == ST_LEAK),
    .refract(refr[idx]),
    .v_next(dp_v),
    .fire(dp_fire),
    .refract_next(dp_r)
  );

  // Weight memory has no reset so it can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (bus_write && !is_reg) wmem[ofs] <= bus_wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      idx          <= '0;
      syn_q        <= '0;
      mask_acc     <= '0;
      spike_valid  <= 1'b0;
      spike_mask   <= '0;
      bus_rdata    <= '0;
      thresh       <= DW'(THRESH_RESET);
      leak_pending <= 1'b0;
      leak_overrun <= 1'b0;
      for (int i = 0; i < NUM_NEURONS; i++) begin
        pot[i]  <= '0;
        refr[i] <= '0;
      end
    end else begin
      spike_valid <= 1'b0;
      if (bus_read) bus_rdata <= rd_mux;

      // Overrun set takes precedence over the clear-on-read of status.
      if (bus_read && stat_hit) leak_overrun <= 1'b0;
      if (leak_tick && leak_pending && !leak_start) leak_overrun <= 1'b1;
      if (leak_start) leak_pending <= 1'b0;
      if (leak_tick) leak_pending <= 1'b1;

      if (bus_write && state == ST_IDLE) begin
        if (pot_hit)      pot[ofs[NW-1:0]] <= bus_wdata;
        else if (thr_hit) thresh <= bus_wdata;
      end

      case (state)
        ST_IDLE: begin
          if (leak_start) begin
            state <= ST_LEAK;
            idx   <= '0;
          end else if (accept) begin
            state    <= ST_ACCUM;
            idx      <= '0;
            syn_q    <= evt_synapse;
            mask_acc <= '0;
          end
        end
        ST_ACCUM: begin
          pot[idx]      <= dp_v;
          refr[idx]     <= dp_r;
          mask_acc[idx] <= dp_fire;
          if (idx == NW'(NUM_NEURONS - 1)) begin
            state       <= ST_DONE;
            spike_valid <= 1'b1;
            spike_mask  <= mask_acc | (NUM_NEURONS'(dp_fire) << idx);
          end else begin
            idx <= idx + NW'(1);
          end
        end
        ST_DONE: begin
          idx   <= '0;
          state <= leak_start ? ST_LEAK : ST_IDLE;
        end
        ST_LEAK: begin
          pot[idx]  <= dp_v;
          refr[idx] <= dp_r;
          if (idx == NW'(NUM_NEURONS - 1)) state <= ST_IDLE;
          else                             idx   <= idx + NW'(1);
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lif_neuron_array.sv
// Bench for lif_neuron_array: directed scenarios plus random traffic checked
// against a transaction-level model of the neuron array.
module tb_lif_neuron_array;

  localparam int NN = 4;
  localparam int NS = 8;
  localparam int DW = 16;
  localparam int AW = 6;
  localparam int SW = 3;
  localparam int RT = 2;
  localparam int REG_BASE = 32;
  localparam int A_THR = REG_BASE + NN;
  localparam int A_STAT = REG_BASE + NN + 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          bus_read = 1'b0;
  logic          bus_write = 1'b0;
  logic [AW-1:0] bus_addr = '0;
  logic [DW-1:0] bus_wdata = '0;
  logic [DW-1:0] bus_rdata;
  logic          evt_valid = 1'b0;
  logic          evt_ready;
  logic [SW-1:0] evt_synapse = '0;
  logic          leak_tick = 1'b0;
  logic          spike_valid;
  logic [NN-1:0] spike_mask;
  logic [1:0]    dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Behavioural model state
  int m_w[NN][NS];
  int m_v[NN];
  int m_r[NN];
  int m_thr;
  logic [NN-1:0] exp_q[$];
  int            exp_cyc_q[$];
  logic [NN-1:0] hold_mask = '0;

  lif_neuron_array dut (
    .clk(clk), .reset_n(reset_n),
    .bus_read(bus_read), .bus_write(bus_write), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_synapse(evt_synapse),
    .leak_tick(leak_tick), .spike_valid(spike_valid), .spike_mask(spike_mask),
    .dbg_state(dbg_state)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: timed out waiting for the DUT", name);
  endtask

  // Model
  function automatic int sat16(input int s);
    if (s > 32767) return 32767;
    if (s < -32768) return -32768;
    return s;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NN; i++) begin
      m_v[i] = 0;
      m_r[i] = 0;
    end
    m_thr = 1000;
  endfunction

  function automatic logic [NN-1:0] model_event(input int syn);
    logic [NN-1:0] m;
    int s;
    m = '0;
    for (int i = 0; i < NN; i++) begin
      if (m_r[i] == 0) begin
        s = sat16(m_v[i] + m_w[i][syn]);
        if (s >= m_thr) begin
          m_v[i] = 0;
          m_r[i] = RT;
          m[i] = 1'b1;
        end else begin
          m_v[i] = s;
        end
      end
    end
    return m;
  endfunction

  function automatic void model_leak();
    int q;
    for (int i = 0; i < NN; i++) begin
      q = (m_v[i] >= 0) ? m_v[i] / 16 : -((-m_v[i] + 15) / 16);
      m_v[i] = m_v[i] - q;
      if (m_r[i] > 0) m_r[i] = m_r[i] - 1;
    end
  endfunction

  // Compare process: spike pulse timing and held mask, every cycle
  always @(negedge clk) begin
    if (exp_cyc_q.size() > 0 && exp_cyc_q[0] == cyc) begin
      hold_mask = exp_q.pop_front();
      void'(exp_cyc_q.pop_front());
      check("spike_valid_pulse", int'(spike_valid), 1);
    end else begin
      check("spike_valid_quiet", int'(spike_valid), 0);
    end
    check("spike_mask", int'(spike_mask), int'(hold_mask));
  end

  // Driver tasks: each starts and ends 1 time unit after a rising edge
  task automatic bus_wr(input int addr, input int data);
    bus_write = 1'b1;
    bus_addr  = AW'(addr);
    bus_wdata = DW'(data);
    @(posedge clk); #1;
    bus_write = 1'b0;
  endtask

  task automatic rd_check(input string name, input int addr, input int exp);
    logic [DW-1:0] d;
    bus_read = 1'b1;
    bus_addr = AW'(addr);
    @(posedge clk); #1;
    bus_read = 1'b0;
    d = bus_rdata;
    check(name, int'($signed(d)), exp);
  endtask

  task automatic wr_w(input int n, input int s, input int val);
    bus_wr(n * NS + s, val);
    m_w[n][s] = val;
  endtask

  task automatic wr_pot(input int n, input int val);
    bus_wr(REG_BASE + n, val);
    m_v[n] = val;
  endtask

  task automatic wr_thr(input int val);
    bus_wr(A_THR, val);
    m_thr = val;
  endtask

  task automatic send_event(input int syn, output int t);
    bit ok;
    ok = 1'b0;
    t = 0;
    evt_valid = 1'b1;
    evt_synapse = SW'(syn);
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      if (evt_ready) begin
        ok = 1'b1;
        t = cyc;
      end
      @(posedge clk); #1;
    end
    evt_valid = 1'b0;
    if (!ok) fail_timeout("evt_accept");
    else begin
      exp_q.push_back(model_event(syn));
      exp_cyc_q.push_back(t + NN + 1);
    end
  endtask

  task automatic wait_ready(output int c);
    bit ok;
    ok = 1'b0;
    c = 0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      if (evt_ready) begin
        ok = 1'b1;
        c = cyc;
      end
      @(posedge clk); #1;
    end
    if (!ok) fail_timeout("wait_ready");
  endtask

  task automatic event_wait(input int syn);
    int t, c;
    send_event(syn, t);
    wait_ready(c);
  endtask

  task automatic do_tick();
    int c;
    leak_tick = 1'b1;
    @(posedge clk); #1;
    leak_tick = 1'b0;
    model_leak();
    wait_ready(c);
  endtask

  task automatic check_all_pots(input string name);
    for (int i = 0; i < NN; i++) rd_check(name, REG_BASE + i, m_v[i]);
  endtask

  initial begin
    int t, c, op, seen;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdata", int'(bus_rdata), 0);
    check("rst_mask", int'(spike_mask), 0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("rst_ready", int'(evt_ready), 1);
    for (int n = 0; n < NN; n++)
      for (int s = 0; s < NS; s++) wr_w(n, s, 0);
    rd_check("rst_thresh", A_THR, 1000);
    rd_check("rst_status", A_STAT, 0);
    rd_check("rst_v0", REG_BASE, 0);

    // Accumulate and fire
    wr_w(0, 3, 600);
    wr_w(1, 3, -200);
    send_event(3, t);
    wait_ready(c);
    check("ready_latency", c - t, NN + 2);
    rd_check("acc1_v0", REG_BASE + 0, 600);
    rd_check("acc1_v1", REG_BASE + 1, -200);
    send_event(3, t);
    seen = 0;
    for (int k = 0; k < 20 && seen == 0; k++) begin
      @(negedge clk);
      if (spike_valid) begin
        seen = 1;
        check("spike_latency", cyc - t, 5);
        check("fire_mask", int'(spike_mask), 1);
      end
      @(posedge clk); #1;
    end
    if (seen == 0) fail_timeout("spike_wait");
    wait_ready(c);
    rd_check("acc2_v0", REG_BASE + 0, 0);
    rd_check("acc2_v1", REG_BASE + 1, -400);

    // Saturation at both rails
    wr_thr(32767);
    wr_pot(2, 32700);
    wr_w(2, 0, 200);
    wr_pot(3, -32700);
    wr_w(3, 0, -200);
    event_wait(0);
    check("sat_mask", int'(spike_mask), 4);
    rd_check("sat_v2", REG_BASE + 2, 0);
    rd_check("sat_v3", REG_BASE + 3, -32768);

    // Leak
    wr_thr(2000);
    wr_pot(0, 1600);
    wr_pot(1, -1600);
    do_tick();
    rd_check("leak_v0", REG_BASE + 0, 1500);
    rd_check("leak_v1", REG_BASE + 1, -1500);
    rd_check("leak_v3", REG_BASE + 3, -30720);
    wr_pot(0, 15);
    do_tick();
    rd_check("leak_small_v0", REG_BASE + 0, 15);

    // Refractory
    wr_thr(1000);
    wr_pot(0, 0);
    event_wait(3);
    rd_check("refr_pre_v0", REG_BASE + 0, 600);
    event_wait(3);
    event_wait(3);
    rd_check("refr_skip_v0", REG_BASE + 0, 0);
    do_tick();
    event_wait(3);
    rd_check("refr_tick1_v0", REG_BASE + 0, 0);
    do_tick();
    event_wait(3);
    rd_check("refr_tick2_v0", REG_BASE + 0, 600);
    check_all_pots("refr_model_v");

    // Leak ticks during ACCUM: served after DONE, second one overruns
    send_event(3, t);
    leak_tick = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    leak_tick = 1'b0;
    model_leak();
    wait_ready(c);
    check("leak_after_done", c - t, 2 * NN + 2);
    rd_check("overrun_status", A_STAT, 2);
    rd_check("overrun_cleared", A_STAT, 0);
    check_all_pots("leak_accum_v");

    // Register writes during ACCUM are dropped
    send_event(5, t);
    bus_wr(REG_BASE + 1, 1234);
    bus_wr(A_THR, 5);
    wait_ready(c);
    rd_check("drop_v1", REG_BASE + 1, m_v[1]);
    rd_check("drop_thr", A_THR, 1000);

    // Reset in the middle of ACCUM
    wr_pot(2, 900);
    send_event(3, t);
    @(posedge clk); #1;
    reset_n = 1'b0;
    exp_q.delete();
    exp_cyc_q.delete();
    hold_mask = '0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    model_reset();
    repeat (8) @(posedge clk);
    #1;
    check("rst_mid_ready", int'(evt_ready), 1);
    for (int i = 0; i < NN; i++) rd_check("rst_mid_v", REG_BASE + i, 0);
    rd_check("rst_mid_thr", A_THR, 1000);

    // Random traffic
    for (int it = 0; it < 150; it++) begin
      op = int'($urandom_range(0, 9));
      case (op)
        0, 1, 2: wr_w(int'($urandom_range(0, NN - 1)), int'($urandom_range(0, NS - 1)),
                      int'($urandom_range(0, 1600)) - 800);
        3: wr_pot(int'($urandom_range(0, NN - 1)), int'($urandom_range(0, 6000)) - 3000);
        4: wr_thr(int'($urandom_range(200, 3000)));
        5: do_tick();
        default: event_wait(int'($urandom_range(0, NS - 1)));
      endcase
      if (it % 5 == 4) begin
        op = int'($urandom_range(0, NN - 1));
        rd_check("rand_v", REG_BASE + op, m_v[op]);
      end
    end
    check_all_pots("final_v");
    rd_check("final_thr", A_THR, m_thr);

    repeat (10) @(posedge clk);
    #1;
    check("spike_queue_drained", exp_cyc_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
